// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared single-port memory.
// The slave modport is the arbiter's view; master is the requesters plus the memory macro.
interface mem_port_arbiter_if;
  logic        f_req;
  logic [12:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [15:0] f_rdata;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_be;
  logic [12:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;

  logic        v_req;
  logic [12:0] v_addr;
  logic        v_gnt;
  logic        v_rvalid;
  logic [15:0] v_rdata;

  logic [12:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  v_req, v_addr,
    output v_gnt, v_rvalid, v_rdata,
    output mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output v_req, v_addr,
    input  v_gnt, v_rvalid, v_rdata,
    input  mem_addr, mem_we, mem_be, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Same-cycle arbiter for the 16-bit single-port memory: VGA first (burst-limited),
// fetch and load/store round-robin, 1-cycle read return tagged by requester.
module mem_port_arbiter #(
  parameter int VGA_MAX_BURST = 7
) (
  input  logic clk,
  input  logic rst_n_async,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] MAX_BURST = 4'(VGA_MAX_BURST);

  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_F = 2'd1, TAG_D = 2'd2, TAG_V = 2'd3} tag_e;
  typedef enum logic {RR_F = 1'b0, RR_D = 1'b1} rr_e;

  tag_e       tag_q, tag_d;
  rr_e        rr_q, rr_d;
  logic [3:0] streak_q, streak_d;
  logic       cpu_req, vga_blocked, v_win, f_win, d_win;

  // Grants are masked while reset is held so nothing reaches the memory.
  always_comb begin
    cpu_req     = bus.f_req | bus.d_req;
    vga_blocked = (streak_q == MAX_BURST) && cpu_req;
    v_win       = rst_n_async && bus.v_req && !vga_blocked;
    f_win       = rst_n_async && !v_win && bus.f_req && (!bus.d_req || rr_q == RR_D);
    d_win       = rst_n_async && !v_win && bus.d_req && (!bus.f_req || rr_q == RR_F);
  end

  assign bus.v_gnt = v_win;
  assign bus.f_gnt = f_win;
  assign bus.d_gnt = d_win;

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 2'b00;
    bus.mem_wdata = '0;
    if (v_win) begin
      bus.mem_addr = bus.v_addr;
    end else if (f_win) begin
      bus.mem_addr = bus.f_addr;
    end else if (d_win) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_we ? bus.d_be : 2'b00;
      bus.mem_wdata = bus.d_wdata;
    end
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (v_win)                    tag_d = TAG_V;
    else if (f_win)               tag_d = TAG_F;
    else if (d_win && !bus.d_we)  tag_d = TAG_D;

    rr_d = rr_q;
    if (f_win)      rr_d = RR_F;
    else if (d_win) rr_d = RR_D;

    // Streak saturates so VGA can keep streaming when the CPU is idle.
    streak_d = '0;
    if (v_win) streak_d = (streak_q >= MAX_BURST) ? MAX_BURST : streak_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n_async) begin
    if (!rst_n_async) begin
      tag_q    <= TAG_NONE;
      rr_q     <= RR_D;
      streak_q <= '0;
    end else begin
      tag_q    <= tag_d;
      rr_q     <= rr_d;
      streak_q <= streak_d;
    end
  end

  assign bus.f_rvalid = (tag_q == TAG_F);
  assign bus.d_rvalid = (tag_q == TAG_D);
  assign bus.v_rvalid = (tag_q == TAG_V);
  assign bus.f_rdata  = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;
  assign bus.v_rdata  = bus.mem_rdata;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port 16-bit instruction/data memory among three requesters: instruction fetch, the load/store unit, and the VGA line reader.
- Same-cycle grant with fixed 1-cycle synchronous read latency. The VGA reader has priority, bounded by a burst limit so the CPU cannot starve.
- Fetch and data share the remaining slots round-robin.
- Sits between the fetch/load-store/VGA units and the memory macro.

Parameters:
- VGA_MAX_BURST, 7, max consecutive VGA grants while another requester is waiting; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n_async  in  1  reset; one clock; reset is asynchronous and active-low
- f_req  in  1  fetch read request
- f_addr  in  13  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  f_rdata valid
- f_rdata  out  16  fetch read data
- d_req  in  1  load/store request
- d_we  in  1  1 = write, 0 = read
- d_be  in  2  write byte enables; [1] = bits 15:8
- d_addr  in  13  load/store word address
- d_wdata  in  16  write data
- d_gnt  out  1  load/store accepted
- d_rvalid  out  1  d_rdata valid (reads only)
- d_rdata  out  16  load read data
- v_req  in  1  VGA read request
- v_addr  in  13  VGA word address
- v_gnt  out  1  VGA accepted
- v_rvalid  out  1  v_rdata valid
- v_rdata  out  16  VGA read data
- mem_addr  out  13  memory word address
- mem_we  out  1  memory write strobe
- mem_be  out  2  memory byte enables
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data; valid 1 cycle after address

Behaviour:
- Handshake
  - Requester holds req/addr/we/be/wdata stable until it sees gnt high.
  - Each cycle with gnt high is exactly one transaction.
  - Keeping req high after gnt issues the next transaction, back-to-back.
- Grant
  - Combinational from current req and registered state; at most one gnt per cycle.
  - Winner's addr/we/be/wdata are muxed onto mem_* in the same cycle.
- Idle cycle (no req)
  - mem_addr=0, mem_we=0, mem_be=2'b00, mem_wdata=0.
  - For reads and for fetch/VGA grants: mem_we=0, mem_be=2'b00.
- Priority
  - 1) VGA, unless vga_streak==VGA_MAX_BURST and (f_req|d_req).
  - 2) Otherwise fetch vs data by round-robin.
  - rr_last (1 bit, reg) records the last CPU-side winner; on a tie the other requester wins.
  - rr_last updates only on f or d grants.
- vga_streak (4-bit reg)
  - +1 on each v_gnt, saturating at VGA_MAX_BURST.
  - Cleared in any cycle without v_gnt.
  - At the limit with f_req|d_req pending, the f/d winner is granted for one cycle and the streak clears.
  - At the limit with no CPU request, VGA keeps its grant.
- Read return
  - Registered 2-bit tag {none,F,D,V} captured at grant (reads only).
  - Next cycle, the matching rvalid=1 for exactly one cycle.
  - f_rdata/d_rdata/v_rdata are all wired to mem_rdata; only rvalid qualifies them.
  - Writes produce no rvalid.
- Throughput and latency: one transaction per cycle max; read latency = 1 cycle after gnt. A read granted in cycle N and another in N+1 give rvalids in N+1 and N+2.
- d_we=1 with d_be=2'b00: granted normally, mem_we=1, mem_be=0; memory is unchanged.
- Reset
  - While rst_n_async=0: all gnt=0, mem_we=0, mem_be=0.
  - Asynchronously: rvalid=0, tag=none, vga_streak=0, rr_last=D, so fetch wins the first tie.
  - A read in flight when reset asserts is dropped; no rvalid after release.
- State
  - Registers: tag, vga_streak, rr_last.
  - No FSM beyond these; no queuing. Requester-side buffering is the requester's job.

Test Plan:
- Release reset; f_req=1, f_addr=0x0001, mem[1]=0x1234 -> f_gnt=1 same cycle, mem_addr=0x0001; next cycle f_rvalid=1, f_rdata=0x1234; v_rvalid=d_rvalid=0.
- f_req=d_req=1 held 6 cycles, v_req=0, all reads -> grant order F,D,F,D,F,D; each rvalid exactly one cycle after its grant.
- v_req=f_req=1 held 24 cycles, VGA_MAX_BURST=7 -> V×7, F×1, V×7, F×1, V×7, F×1. With f_req=0 instead -> V every cycle.
- Data write d_addr=0x0100, d_wdata=0xBEEF, d_be=2'b11, then fetch read of 0x0100 -> mem_we=1 for one cycle, no d_rvalid; f_rdata=0xBEEF. Repeat with d_be=2'b01 and d_wdata=0x00AA -> read 0xBEAA.
- v_req, f_req, d_req all asserted at vga_streak=0 -> v_gnt=1, f_gnt=d_gnt=0; f and d hold and are served at the next CPU slot (F first after reset).
- v read granted, rst_n_async driven low before the next edge for 2 cycles -> v_rvalid never asserts, all gnt=0 during reset; after release the first f/d tie goes to F.
